btn_cmd_ctrl: RTL and testbench



---
 rtl/btn_cmd_ctrl_pkg.sv | 14 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/btn_cmd_ctrl.sv | 82 ++++++++
 tb/tb_btn_cmd_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/btn_cmd_ctrl_pkg.sv
// Shared constants for the counter command path.
// Bit positions of the sw word and debounce lengths.
package btn_cmd_ctrl_pkg;

   localparam int SW_W = 3;

   localparam int SW_MODE  = 0;
   localparam int SW_RUN   = 1;
   localparam int SW_CLEAR = 2;

   localparam int DB_CYCLES_DEFAULT = 1_000_000;
   localparam int DB_CYCLES_SIM     = 4;

endpackage

// File: rtl/btn_debounce.sv
// Per-button 2-FF synchroniser, debouncer and press edge detector.
// Ports: clk, reset (sync, high), btn_in raw, level debounced, rise pulse.
module btn_debounce
   import btn_cmd_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
   localparam int CNT_W    = $clog2(DB_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             sync_a;
   logic             sync_s;
   logic             db;
   logic             db_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= 1'b0;
         sync_s <= 1'b0;
         db     <= 1'b0;
         db_d   <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_a <= btn_in;
         sync_s <= sync_a;
         db_d   <= db;
         // any return to the accepted level restarts qualification
         if (sync_s == db) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            db  <= sync_s;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = db;
   assign rise  = db & ~db_d;

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Turns three bouncy buttons into the counter's sw command word.
// Ports: clk, reset, btn_mode/run/clear raw; sw command, press pulses.
module btn_cmd_ctrl
   import btn_cmd_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            btn_mode,
   input  logic            btn_run,
   input  logic            btn_clear,
   output logic [SW_W-1:0] sw,
   output logic [SW_W-1:0] press
);

   logic [SW_W-1:0] lvl;
   logic [SW_W-1:0] rise;
   logic            mode_q;
   logic            mode_n;
   logic            run_q;
   logic            run_n;
   logic            unused_lvl;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_mode),
      .level  (lvl[SW_MODE]),
      .rise   (rise[SW_MODE])
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_run),
      .level  (lvl[SW_RUN]),
      .rise   (rise[SW_RUN])
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_clear),
      .level  (lvl[SW_CLEAR]),
      .rise   (rise[SW_CLEAR])
   );

   // mode and run act on presses only; their levels have no consumer
   assign unused_lvl = &{1'b0, lvl[SW_RUN], lvl[SW_MODE]};

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q <= 1'b0;
         run_q  <= 1'b0;
      end else begin
         mode_q <= mode_n;
         run_q  <= run_n;
      end
   end

   // clear level covers its own rise cycle, so it beats a same-cycle run press
   always_comb begin
      mode_n = mode_q ^ rise[SW_MODE];
      run_n  = run_q;
      priority case (1'b1)
         lvl[SW_CLEAR]: run_n = 1'b0;
         rise[SW_RUN]:  run_n = ~run_q;
         default:       run_n = run_q;
      endcase
   end

   always_comb begin
      sw           = '0;
      sw[SW_MODE]  = mode_q;
      sw[SW_RUN]   = run_q;
      sw[SW_CLEAR] = lvl[SW_CLEAR];
   end

   assign press = rise;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Directed bench for btn_cmd_ctrl with a 4-cycle debounce.
// Expected values are hand-derived edge by edge.
module tb_btn_cmd_ctrl;
   import btn_cmd_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] btn;
   logic [2:0] sw;
   logic [2:0] press;

   int errs = 0;
   int nchk = 0;

   always #5 clk = ~clk;

   btn_cmd_ctrl #(.DB_CYCLES(DB_CYCLES_SIM)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_mode  (btn[0]),
      .btn_run   (btn[1]),
      .btn_clear (btn[2]),
      .sw        (sw),
      .press     (press)
   );

   task automatic check(input string tag,
                        input logic [7:0] got,
                        input logic [7:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // one edge, then settle so outputs are sampled away from it
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // full press then full release, each long enough to qualify
   task automatic tap(input logic [2:0] m);
      btn = btn | m;
      tick(8);
      btn = btn & ~m;
      tick(8);
   endtask

   initial begin
      reset = 1'b1;
      btn   = 3'b000;

      // reset then idle
      tick(1);
      check("rst_sw", 8'(sw), 8'h00);
      check("rst_press", 8'(press), 8'h00);
      tick(1);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         check("idle", {2'b0, press, sw}, 8'h00);
      end

      // clean run press: rise after edge 5, toggle at edge 6
      btn[1] = 1'b1;
      tick(5);
      check("run_e4_press", 8'(press), 8'h00);
      tick(1);
      check("run_e5_press", 8'(press), 8'h02);
      check("run_e5_sw", 8'(sw), 8'h00);
      tick(1);
      check("run_e6_press", 8'(press), 8'h00);
      check("run_e6_sw", 8'(sw), 8'h02);
      for (int i = 0; i < 13; i++) begin
         tick(1);
         check("run_hold", {2'b0, press, sw}, 8'h02);
      end
      btn[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("run_rel", {2'b0, press, sw}, 8'h02);
      end
      btn[1] = 1'b1;
      tick(7);
      check("run_again", 8'(sw), 8'h00);
      btn[1] = 1'b0;
      tick(8);

      // bounce: 2-cycle toggles never qualify
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) btn[1] = ~btn[1];
         tick(1);
         check("bounce_press", 8'(press), 8'h00);
      end
      btn[1] = 1'b0;
      tick(10);
      check("bounce_sw", 8'(sw), 8'h00);

      // 3-cycle glitch, 1 low, then stable high from edge 4
      btn[1] = 1'b1;
      tick(3);
      btn[1] = 1'b0;
      tick(1);
      btn[1] = 1'b1;
      tick(5);
      check("glitch_e8", {2'b0, press, sw}, 8'h00);
      tick(1);
      check("glitch_e9", 8'(press), 8'h02);
      tick(1);
      check("glitch_e10", 8'(sw), 8'h02);
      btn[1] = 1'b0;
      tick(8);

      // clear priority with run on, both pressed together
      btn[2] = 1'b1;
      btn[1] = 1'b1;
      tick(6);
      check("clr_e5_press", 8'(press), 8'h06);
      check("clr_e5_sw", 8'(sw), 8'h06);
      tick(1);
      check("clr_e6_sw", 8'(sw), 8'h04);
      btn[1] = 1'b0;
      tick(8);
      // run press while clear held is ignored
      btn[1] = 1'b1;
      tick(6);
      check("clr_run_press", 8'(press), 8'h02);
      tick(1);
      check("clr_run_sw", 8'(sw), 8'h04);
      btn[1] = 1'b0;
      tick(8);
      check("clr_run_rel", 8'(sw), 8'h04);
      btn[2] = 1'b0;
      tick(5);
      check("clr_rel_e4", 8'(sw), 8'h04);
      tick(1);
      check("clr_rel_e5", 8'(sw), 8'h00);
      tick(4);
      check("clr_rel_late", {2'b0, press, sw}, 8'h00);

      // mode independence
      tap(3'b010);
      check("mode_pre", 8'(sw), 8'h02);
      btn[0] = 1'b1;
      tick(6);
      check("mode_press", 8'(press), 8'h01);
      tick(1);
      check("mode_on", 8'(sw), 8'h03);
      btn[0] = 1'b0;
      tick(8);
      check("mode_rel", 8'(sw), 8'h03);
      tap(3'b001);
      check("mode_off", 8'(sw), 8'h02);
      tap(3'b001);
      check("mode_back", 8'(sw), 8'h03);

      // reset with run held mid-debounce
      btn[1] = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(1);
      check("mrst_sw", 8'(sw), 8'h00);
      check("mrst_press", 8'(press), 8'h00);
      reset = 1'b0;
      tick(5);
      check("mrst_e4", {2'b0, press, sw}, 8'h00);
      tick(1);
      check("mrst_e5", 8'(press), 8'h02);
      tick(1);
      check("mrst_e6", 8'(sw), 8'h02);
      btn[1] = 1'b0;
      tick(8);
      check("mrst_end", 8'(sw), 8'h02);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
